// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational alu between NUM_REQ requesters.
// Round-robin by default; define ALU_ARB_FIXED_PRIO_EN for lowest-index-wins.
module alu_arbiter #(
    parameter int BIT_LENGTH = 4,
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*BIT_LENGTH-1:0] req_a,
    input  logic [NUM_REQ*BIT_LENGTH-1:0] req_b,
    input  logic [NUM_REQ*3-1:0]          req_opcode,
    input  logic [NUM_REQ-1:0]            req_funct,
    output logic [BIT_LENGTH-1:0]         alu_a,
    output logic [BIT_LENGTH-1:0]         alu_b,
    output logic [2:0]                    alu_opcode,
    output logic                          alu_funct,
    output logic                          alu_exec_en,
    input  logic [BIT_LENGTH-1:0]         alu_out,
    input  logic                          alu_cb,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [BIT_LENGTH-1:0]         rsp_out,
    output logic                          rsp_cb,
    output logic                          rsp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [BIT_LENGTH-1:0] a_q, a_d;
    logic [BIT_LENGTH-1:0] b_q, b_d;
    logic [2:0]            op_q, op_d;
    logic                  funct_q, funct_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic                  err_q, err_d;
    logic [BIT_LENGTH-1:0] rsp_out_q, rsp_out_d;
    logic                  rsp_cb_q, rsp_cb_d;

    logic [ID_W-1:0]       scan_start;
    logic                  found;
    logic [ID_W-1:0]       win;
    logic [2:0]            win_op;
    logic                  win_funct;
    logic                  win_undef;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign scan_start = '0;
`else
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;

    assign scan_start = rr_ptr_q;

    // Pointer moves just past the requester granted this cycle.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == IDLE && found) begin
            if (win == ID_W'(NUM_REQ - 1))
                rr_ptr_d = '0;
            else
                rr_ptr_d = win + ID_W'(1);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr_q <= '0;
        else
            rr_ptr_q <= rr_ptr_d;
    end
`endif

    // First valid requester at or after scan_start, wrapping around.
    always_comb begin : scan
        int              k;
        logic [ID_W-1:0] idx;
        found = 1'b0;
        win   = '0;
        k     = 0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(scan_start) + i;
            if (k >= NUM_REQ)
                k = k - NUM_REQ;
            idx = ID_W'(k);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign win_op    = req_opcode[int'(win)*3 +: 3];
    assign win_funct = req_funct[win];

    // Encodings 1000, 1011, 1110 and 1111 have no alu operation.
    assign win_undef = win_funct &&
                       (win_op == 3'b000 || win_op == 3'b011 ||
                        win_op == 3'b110 || win_op == 3'b111);

    // Next-state and operand/response capture.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        funct_d   = funct_q;
        id_d      = id_q;
        err_d     = err_q;
        rsp_out_d = rsp_out_q;
        rsp_cb_d  = rsp_cb_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    a_d     = req_a[int'(win)*BIT_LENGTH +: BIT_LENGTH];
                    b_d     = req_b[int'(win)*BIT_LENGTH +: BIT_LENGTH];
                    op_d    = win_op;
                    funct_d = win_funct;
                    id_d    = win;
                    err_d   = win_undef;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_out_d = err_q ? '0 : alu_out;
                rsp_cb_d  = err_q ? 1'b0 : alu_cb;
                state_d   = RESP;
            end
            RESP: begin
                if (rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight work.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            funct_q   <= 1'b0;
            id_q      <= '0;
            err_q     <= 1'b0;
            rsp_out_q <= '0;
            rsp_cb_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            funct_q   <= funct_d;
            id_q      <= id_d;
            err_q     <= err_d;
            rsp_out_q <= rsp_out_d;
            rsp_cb_q  <= rsp_cb_d;
        end
    end

    logic in_idle, in_exec, in_resp;

    assign in_idle = (state_q == IDLE);
    assign in_exec = (state_q == EXEC);
    assign in_resp = (state_q == RESP);

    // Grant is gated by rst so it drops the instant reset rises.
    assign req_ready = (in_idle && found && !rst) ?
                       (NUM_REQ'(1) << win) : '0;

    assign alu_a       = in_exec ? a_q : '0;
    assign alu_b       = in_exec ? b_q : '0;
    assign alu_opcode  = in_exec ? op_q : '0;
    assign alu_funct   = in_exec ? funct_q : 1'b0;
    assign alu_exec_en = in_exec && !err_q;

    assign rsp_valid = in_resp;
    assign rsp_id    = in_resp ? id_q : '0;
    assign rsp_out   = in_resp ? rsp_out_q : '0;
    assign rsp_cb    = in_resp ? rsp_cb_q : 1'b0;
    assign rsp_err   = in_resp ? err_q : 1'b0;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed-vector bench for alu_arbiter with a small alu model.
// Honours ALU_ARB_FIXED_PRIO_EN for the priority scenario.
module tb_alu_arbiter;

    localparam int BL = 4;
    localparam int NR = 4;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*BL-1:0] req_a;
    logic [NR*BL-1:0] req_b;
    logic [NR*3-1:0]  req_opcode;
    logic [NR-1:0]    req_funct;
    logic [BL-1:0]    alu_a;
    logic [BL-1:0]    alu_b;
    logic [2:0]       alu_opcode;
    logic             alu_funct;
    logic             alu_exec_en;
    logic [BL-1:0]    alu_out;
    logic             alu_cb;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IW-1:0]    rsp_id;
    logic [BL-1:0]    rsp_out;
    logic             rsp_cb;
    logic             rsp_err;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    alu_arbiter #(
        .BIT_LENGTH(BL),
        .NUM_REQ   (NR),
        .ID_W      (IW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_opcode (req_opcode),
        .req_funct  (req_funct),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_funct  (alu_funct),
        .alu_exec_en(alu_exec_en),
        .alu_out    (alu_out),
        .alu_cb     (alu_cb),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_out    (rsp_out),
        .rsp_cb     (rsp_cb),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in alu: add, subtract, else xor; X when not enabled.
    always_comb begin
        {alu_cb, alu_out} = 'x;
        if (alu_exec_en) begin
            case ({alu_funct, alu_opcode})
                4'b0000: {alu_cb, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
                4'b0001: {alu_cb, alu_out} = {1'b0, alu_a} - {1'b0, alu_b};
                default: {alu_cb, alu_out} = {1'b0, alu_a ^ alu_b};
            endcase
        end
    end

    task automatic set_req(input int i, input logic [BL-1:0] a,
                           input logic [BL-1:0] b, input logic [2:0] op,
                           input logic f);
        req_a[i*BL +: BL]    = a;
        req_b[i*BL +: BL]    = b;
        req_opcode[i*3 +: 3] = op;
        req_funct[i]         = f;
        req_valid[i]         = 1'b1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Leaves the caller at a negedge with a grant showing, or after 12 cycles.
    task automatic wait_grant();
        int n;
        n = 0;
        @(negedge clk);
        while (req_ready === '0 && n < 12) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_opcode = '0;
        req_funct  = '0;
        rsp_ready  = 1'b0;
        #1 rst = 1'b1;
        #2;
        vectors++;
        if ({req_ready, rsp_valid, rsp_id, rsp_out, rsp_cb, rsp_err,
             alu_a, alu_b, alu_opcode, alu_funct, alu_exec_en} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got rdy=%b rv=%b en=%b want all 0",
                     req_ready, rsp_valid, alu_exec_en);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_add();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 set_req(0, 4'd9, 4'd8, 3'b000, 1'b0);
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL add_grant got %b want 0001", req_ready);
        end
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        vectors++;
        if ({alu_exec_en, alu_a, alu_b, alu_opcode, alu_funct, req_ready}
            !== {1'b1, 4'd9, 4'd8, 3'b000, 1'b0, 4'b0000}) begin
            miscompares++;
            $display("FAIL add_exec got en=%b a=%h b=%h rdy=%b want 1 9 8 0000",
                     alu_exec_en, alu_a, alu_b, req_ready);
        end
        @(negedge clk);
        vectors++;
        if ({rsp_valid, rsp_id, rsp_out, rsp_cb, rsp_err}
            !== {1'b1, 2'd0, 4'h1, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL add_rsp got v=%b id=%0d out=%h cb=%b err=%b want 1 0 1 1 0",
                     rsp_valid, rsp_id, rsp_out, rsp_cb, rsp_err);
        end
        @(negedge clk);
        vectors++;
        if ({rsp_valid, alu_exec_en, req_ready} !== 6'b0) begin
            miscompares++;
            $display("FAIL add_idle got v=%b en=%b rdy=%b want 0 0 0000",
                     rsp_valid, alu_exec_en, req_ready);
        end
    endtask

    task automatic test_round_robin();
        int prev;
        int exp;
        pulse_reset();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++)
            set_req(i, BL'(i), 4'd1, 3'b000, 1'b0);
        prev = 0;
        for (int g = 0; g < 5; g++) begin
            exp = g % NR;
            wait_grant();
            vectors++;
            if (req_ready !== NR'(1 << exp)) begin
                miscompares++;
                $display("FAIL rr_grant%0d got %b want %b",
                         g, req_ready, NR'(1 << exp));
            end
            if (g > 0) begin
                vectors++;
                if (cyc - prev !== 3) begin
                    miscompares++;
                    $display("FAIL rr_spacing%0d got %0d want 3", g, cyc - prev);
                end
            end
            prev = cyc;
            @(negedge clk);
            @(negedge clk);
            vectors++;
            if ({rsp_valid, rsp_id, rsp_out, rsp_cb}
                !== {1'b1, IW'(exp), BL'(exp + 1), 1'b0}) begin
                miscompares++;
                $display("FAIL rr_rsp%0d got v=%b id=%0d out=%h cb=%b want 1 %0d %0d 0",
                         g, rsp_valid, rsp_id, rsp_out, rsp_cb, exp, exp + 1);
            end
        end
        req_valid = '0;
        wait_cycles(2);
    endtask

    task automatic test_undefined();
        logic saw_en;
        saw_en = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 set_req(2, 4'd5, 4'd3, 3'b011, 1'b1);
        wait_grant();
        saw_en = saw_en | alu_exec_en;
        vectors++;
        if (req_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL undef_grant got %b want 0100", req_ready);
        end
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        saw_en = saw_en | alu_exec_en;
        @(negedge clk);
        saw_en = saw_en | alu_exec_en;
        vectors++;
        if ({rsp_valid, rsp_id, rsp_out, rsp_cb, rsp_err}
            !== {1'b1, 2'd2, 4'h0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL undef_rsp got v=%b id=%0d out=%h cb=%b err=%b want 1 2 0 0 1",
                     rsp_valid, rsp_id, rsp_out, rsp_cb, rsp_err);
        end
        vectors++;
        if (saw_en !== 1'b0) begin
            miscompares++;
            $display("FAIL undef_exec_en got %b want 0", saw_en);
        end
        wait_cycles(1);
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        @(posedge clk);
        #1 set_req(1, 4'd7, 4'd2, 3'b001, 1'b0);
        wait_grant();
        vectors++;
        if (req_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL bp_grant got %b want 0010", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        set_req(3, 4'd1, 4'd1, 3'b000, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++;
            if ({rsp_valid, rsp_id, rsp_out, rsp_cb, rsp_err, req_ready}
                !== {1'b1, 2'd1, 4'd5, 1'b0, 1'b0, 4'b0000}) begin
                miscompares++;
                $display("FAIL bp_hold%0d got v=%b id=%0d out=%h rdy=%b want 1 1 5 0000",
                         k, rsp_valid, rsp_id, rsp_out, req_ready);
            end
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if ({rsp_valid, req_ready} !== {1'b1, 4'b0000}) begin
            miscompares++;
            $display("FAIL bp_release got v=%b rdy=%b want 1 0000",
                     rsp_valid, req_ready);
        end
        @(negedge clk);
        vectors++;
        if ({rsp_valid, req_ready} !== {1'b0, 4'b1000}) begin
            miscompares++;
            $display("FAIL bp_resume got v=%b rdy=%b want 0 1000",
                     rsp_valid, req_ready);
        end
        @(posedge clk);
        #1 req_valid = '0;
        wait_cycles(3);
    endtask

    task automatic test_reset_mid_exec();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 set_req(1, 4'd2, 4'd2, 3'b000, 1'b0);
        wait_grant();
        @(posedge clk);
        #1 req_valid = '0;
        wait_cycles(3);
        set_req(2, 4'd3, 4'd4, 3'b000, 1'b0);
        wait_grant();
        @(posedge clk);
        #1;
        vectors++;
        if ({alu_exec_en, alu_a, alu_b} !== {1'b1, 4'd3, 4'd4}) begin
            miscompares++;
            $display("FAIL rme_exec got en=%b a=%h b=%h want 1 3 4",
                     alu_exec_en, alu_a, alu_b);
        end
        #2;
        rst = 1'b1;
        for (int i = 0; i < NR; i++)
            set_req(i, BL'(i + 2), 4'd1, 3'b000, 1'b0);
        #1;
        vectors++;
        if ({req_ready, rsp_valid, rsp_id, rsp_out, rsp_cb, rsp_err,
             alu_a, alu_b, alu_opcode, alu_funct, alu_exec_en} !== '0) begin
            miscompares++;
            $display("FAIL rme_zero got rdy=%b en=%b a=%h rv=%b want all 0",
                     req_ready, alu_exec_en, alu_a, rsp_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL rme_grant got %b want 0001", req_ready);
        end
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({rsp_valid, rsp_id, rsp_out} !== {1'b1, 2'd0, 4'd3}) begin
            miscompares++;
            $display("FAIL rme_rsp got v=%b id=%0d out=%h want 1 0 3",
                     rsp_valid, rsp_id, rsp_out);
        end
        wait_cycles(1);
    endtask

    task automatic test_priority();
        logic [NR-1:0] exp_g [4];
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        exp_g = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};
`endif
        pulse_reset();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        set_req(0, 4'd1, 4'd1, 3'b000, 1'b0);
        set_req(3, 4'd2, 4'd2, 3'b000, 1'b0);
        for (int g = 0; g < 4; g++) begin
            wait_grant();
            vectors++;
            if (req_ready !== exp_g[g]) begin
                miscompares++;
                $display("FAIL prio_grant%0d got %b want %b",
                         g, req_ready, exp_g[g]);
            end
            @(negedge clk);
            @(negedge clk);
        end
        req_valid = '0;
        wait_cycles(2);
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_round_robin();
        test_undefined();
        test_backpressure();
        test_reset_mid_exec();
        test_priority();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
